// File: rtl/group_result_drain.sv
// group_result_drain
//
// Output stage of the MAC group. When the accumulation window closes
// (capture), all GROUP_NB signed accumulators are snapshotted together with
// the requantisation controls (shift, relu). The vector is then drained one
// element per handshake over a valid/ready stream, index 0 first. Each element
// is converted to OUT_WIDTH by:
//   - a rounding (half-up) arithmetic right shift,
//   - an optional ReLU,
//   - signed saturation.
//
// All stream outputs are registered. The conversion of the *next* word is done
// combinationally from the buffered vector and loaded into out_data on the
// same edge that advances the index. This keeps full throughput (one word per
// cycle) and leaves no combinational path from inputs to outputs.
//
// A capture that arrives while a vector is still draining is dropped and
// flagged in the sticky overflow bit. The only exception is a capture that
// coincides with the handshake of the final element; that capture is accepted
// back-to-back with no bubble.

module group_result_drain #(
    parameter int GROUP_NB    = 4,
    parameter int IMG_WIDTH   = 16,
    parameter int KER_WIDTH   = 16,
    parameter int OUT_WIDTH   = 16,
    parameter int SHIFT_WIDTH = 5,
    // Derived widths; not intended to be overridden.
    parameter int ACC_WIDTH   = IMG_WIDTH + KER_WIDTH + 1,
    parameter int IDX_WIDTH   = (GROUP_NB > 1) ? $clog2(GROUP_NB) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [GROUP_NB*ACC_WIDTH-1:0] result,
    input  logic                          capture,
    input  logic [SHIFT_WIDTH-1:0]        shift,
    input  logic                          relu,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic [IDX_WIDTH-1:0]          out_idx,
    output logic                          out_last,
    output logic                          out_val,
    input  logic                          out_rdy,
    output logic                          busy,
    output logic                          overflow
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------

    // One guard bit above the accumulator so that adding the rounding
    // constant can never wrap.
    localparam int CALC_WIDTH = ACC_WIDTH + 1;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(GROUP_NB - 1);

    // Saturation bounds for a signed OUT_WIDTH word, expressed in CALC_WIDTH.
    localparam logic signed [CALC_WIDTH-1:0] SAT_MAX =
        CALC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [CALC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Conversion: rounding shift, optional ReLU, signed saturation
    // ------------------------------------------------------------------
    function automatic logic [OUT_WIDTH-1:0] conv(
        input logic signed [ACC_WIDTH-1:0]   x,
        input logic        [SHIFT_WIDTH-1:0] s,
        input logic                          r
    );
        logic signed [CALC_WIDTH-1:0] ext;
        logic signed [CALC_WIDTH-1:0] rnd;
        logic signed [CALC_WIDTH-1:0] y;
        ext = {x[ACC_WIDTH-1], x};
        rnd = '0;
        if (s == '0) begin
            y = ext;
        end else if (int'(s) >= ACC_WIDTH) begin
            // The half-LSB rounding constant already dominates every
            // representable accumulator value. Round-half-up therefore
            // lands on zero for the whole input range.
            y = '0;
        end else begin
            rnd = {{(CALC_WIDTH-1){1'b0}}, 1'b1} << (s - 1'b1);
            y   = (ext + rnd) >>> s;
        end
        if (r && y[CALC_WIDTH-1]) begin
            y = '0;
        end
        if (y > SAT_MAX) begin
            y = SAT_MAX;
        end else if (y < SAT_MIN) begin
            y = SAT_MIN;
        end
        return y[OUT_WIDTH-1:0];
    endfunction

    // Extract element i of a packed accumulator vector.
    function automatic logic signed [ACC_WIDTH-1:0] elem(
        input logic [GROUP_NB*ACC_WIDTH-1:0] vec,
        input int                            i
    );
        return vec[i*ACC_WIDTH +: ACC_WIDTH];
    endfunction

    // ------------------------------------------------------------------
    // State and buffered vector
    // ------------------------------------------------------------------
    state_t                        state;
    logic [GROUP_NB*ACC_WIDTH-1:0] vec_q;
    logic [SHIFT_WIDTH-1:0]        shift_q;
    logic                          relu_q;

    logic                          hs;
    logic                          accept;
    logic                          drop;
    logic [IDX_WIDTH-1:0]          nxt_idx;
    int                            src_sel;
    logic signed [ACC_WIDTH-1:0]   src_x;
    logic [SHIFT_WIDTH-1:0]        src_s;
    logic                          src_r;
    logic [OUT_WIDTH-1:0]          conv_word;

    // Handshake, capture acceptance and the source of the next output word.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        hs        = out_val & out_rdy;
        accept    = capture & ((state == IDLE) | (hs & out_last));
        drop      = capture & ~accept;
        nxt_idx   = out_idx + 1'b1;
        src_sel   = (out_idx == LAST_IDX) ? 0 : int'(out_idx) + 1;
        src_x     = elem(vec_q, src_sel);
        src_s     = shift_q;
        src_r     = relu_q;
        if (accept) begin
            // The word leaving the register on the next edge is element 0
            // of the vector being captured now, converted with the controls
            // being captured now.
            src_x = elem(result, 0);
            src_s = shift;
            src_r = relu;
        end
        conv_word = conv(src_x, src_s, src_r);
    end

    // Snapshot of the accumulators and controls on an accepted capture.
    // NOTE: pure datapath storage is deliberately left out of reset. It is
    // only read while the FSM is in SEND, which requires a fresh capture
    // after reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            vec_q   <= result;
            shift_q <= shift;
            relu_q  <= relu;
        end
    end

    // Stream FSM with registered outputs and the sticky overflow flag.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments, so every
        // right-hand side sees the pre-edge values.
        if (rst) begin
            state    <= IDLE;
            out_val  <= 1'b0;
            out_data <= '0;
            out_idx  <= '0;
            out_last <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end
            if (accept) begin
                state    <= SEND;
                out_val  <= 1'b1;
                busy     <= 1'b1;
                out_idx  <= '0;
                out_last <= (GROUP_NB == 1);
                out_data <= conv_word;
            end else if (state == SEND && hs) begin
                if (out_last) begin
                    state    <= IDLE;
                    out_val  <= 1'b0;
                    busy     <= 1'b0;
                    out_last <= 1'b0;
                end else begin
                    out_idx  <= nxt_idx;
                    out_last <= (nxt_idx == LAST_IDX);
                    out_data <= conv_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_group_result_drain.sv
// Testbench for group_result_drain: directed vectors plus randomized traffic.
// Expected words come from an arithmetic model of the conversion rules and are
// queued by the stimulus process. A negedge monitor compares them in order
// against whatever the DUT presents.
module tb_group_result_drain;

    localparam int GROUP_NB    = 4;
    localparam int IMG_WIDTH   = 16;
    localparam int KER_WIDTH   = 16;
    localparam int OUT_WIDTH   = 16;
    localparam int SHIFT_WIDTH = 5;
    localparam int ACC_WIDTH   = IMG_WIDTH + KER_WIDTH + 1;
    localparam int IDX_WIDTH   = 2;

    typedef struct {
        logic [OUT_WIDTH-1:0] data;
        int                   idx;
        bit                   last;
    } exp_t;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [GROUP_NB*ACC_WIDTH-1:0] result;
    logic                          capture;
    logic [SHIFT_WIDTH-1:0]        shift;
    logic                          relu;
    logic [OUT_WIDTH-1:0]          out_data;
    logic [IDX_WIDTH-1:0]          out_idx;
    logic                          out_last;
    logic                          out_val;
    logic                          out_rdy;
    logic                          busy;
    logic                          overflow;

    group_result_drain #(
        .GROUP_NB(GROUP_NB), .IMG_WIDTH(IMG_WIDTH), .KER_WIDTH(KER_WIDTH),
        .OUT_WIDTH(OUT_WIDTH), .SHIFT_WIDTH(SHIFT_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .result(result), .capture(capture),
        .shift(shift), .relu(relu), .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last), .out_val(out_val), .out_rdy(out_rdy),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int     vectors    = 0;
    int     miscompares = 0;
    exp_t   q[$];
    bit     exp_ovf    = 1'b0;
    bit     mon_en     = 1'b0;
    bit     hold_v     = 1'b0;
    logic [OUT_WIDTH-1:0] hold_d;
    logic [IDX_WIDTH-1:0] hold_i;
    longint cur_e[GROUP_NB];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference conversion: exact integer arithmetic on 64-bit values.
    function automatic logic [OUT_WIDTH-1:0] model(input longint x, input int s, input bit r);
        longint y;
        if (s == 0) y = x;
        else        y = (x + (longint'(1) << (s - 1))) >>> s;
        if (r && y < 0) y = 0;
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
        return y[OUT_WIDTH-1:0];
    endfunction

    task automatic load(input longint a, input longint b, input longint c, input longint d,
                        input int s, input bit r);
        cur_e[0] = a; cur_e[1] = b; cur_e[2] = c; cur_e[3] = d;
        for (int i = 0; i < GROUP_NB; i++) begin
            logic [63:0] v;
            v = cur_e[i];
            result[i*ACC_WIDTH +: ACC_WIDTH] = v[ACC_WIDTH-1:0];
        end
        shift = SHIFT_WIDTH'(s);
        relu  = r;
    endtask

    // One clock of stimulus; called right after a posedge (+1).
    task automatic step(input bit cap, input bit rdy);
        bit acc;
        capture = cap;
        out_rdy = rdy;
        acc = cap && (q.size() == 0 || (q.size() == 1 && rdy));
        @(posedge clk);
        if (acc) begin
            for (int i = 0; i < GROUP_NB; i++) begin
                exp_t e;
                e.data = model(cur_e[i], int'(shift), relu);
                e.idx  = i;
                e.last = (i == GROUP_NB - 1);
                q.push_back(e);
            end
        end else if (cap) begin
            exp_ovf = 1'b1;
        end
        #1;
        capture = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && q.size() != 0; n++) step(1'b0, 1'b1);
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        capture = 1'b0;
        out_rdy = 1'b0;
        @(posedge clk);
        q.delete();
        exp_ovf = 1'b0;
        hold_v  = 1'b0;
        #1;
        check("rst_val",  64'(out_val),  64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_idx",  64'(out_idx),  64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        check("rst_busy", 64'(busy),     64'd0);
        check("rst_ovf",  64'(overflow), 64'd0);
        rst = 1'b0;
    endtask

    // Scoreboard monitor: outputs are sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("out_val",  64'(out_val),  64'(q.size() != 0));
            check("busy",     64'(busy),     64'(q.size() != 0));
            check("overflow", 64'(overflow), 64'(exp_ovf));
            if (q.size() != 0) begin
                check("data", 64'(out_data), 64'(q[0].data));
                check("idx",  64'(out_idx),  64'(q[0].idx));
                check("last", 64'(out_last), 64'(q[0].last));
                if (hold_v) begin
                    check("hold_data", 64'(out_data), 64'(hold_d));
                    check("hold_idx",  64'(out_idx),  64'(hold_i));
                end
            end else begin
                check("last_idle", 64'(out_last), 64'd0);
            end
            hold_v = out_val && !out_rdy;
            hold_d = out_data;
            hold_i = out_idx;
            if (out_val && out_rdy && q.size() != 0) void'(q.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; capture = 1'b0; out_rdy = 1'b0; result = '0; shift = '0; relu = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        mon_en = 1'b1;

        // Plain pass-through with saturation of a large positive value.
        load(5, -3, 100, 64'h7FFFF, 0, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        check("t1_done", 64'(q.size()), 64'd0);

        // Rounding shift with negative saturation, then with ReLU.
        load(24, -24, 7, -(longint'(1) << 32), 4, 1'b0);
        step(1'b1, 1'b1);
        drain();
        load(24, -24, 7, -(longint'(1) << 32), 4, 1'b1);
        step(1'b1, 1'b1);
        drain();

        // Back-pressure pattern.
        load(1000, -1000, 12345, -77, 1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b1);
        step(1'b0, 1'b0); step(1'b0, 1'b1); step(1'b0, 1'b1);
        check("stall_done", 64'(q.size()), 64'd0);

        // Capture at 2nd handshake is dropped; capture on last is accepted.
        load(11, 22, 33, 44, 0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        load(-9, -8, -7, -6, 0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        load(300, -300, 65536, -65536, 2, 1'b0);
        step(1'b1, 1'b1);
        drain();

        // Reset while element 2 is on the bus.
        load(50, 60, 70, 80, 0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        do_reset();
        load(-1, -2, -3, -4, 0, 1'b0);
        step(1'b1, 1'b1);
        drain();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            bit cap;
            cap = ($urandom_range(0, 3) == 0);
            if (cap) begin
                longint v[GROUP_NB];
                for (int i = 0; i < GROUP_NB; i++) begin
                    logic [63:0] raw;
                    raw = {$urandom, $urandom};
                    case ($urandom_range(0, 2))
                        0: v[i] = longint'($signed(raw[15:0]));
                        1: v[i] = longint'($signed(raw[23:0]));
                        default: v[i] = longint'($signed(raw[32:0]));
                    endcase
                end
                load(v[0], v[1], v[2], v[3], int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            end
            step(cap, ($urandom_range(0, 3) != 0));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
